// File: rtl/maclaurin_pkg.sv
// Shared definitions for the Maclaurin series pipe controller.
//
// Contents:
//   STAGES_DEF / PASSES_DEF : default pipe depth and traversals per operand
//   tag_width()             : width of a pass tag for a given pass count (minimum 1)
//   TAG_W_DEF               : tag width for the default configuration
//   pass_tag_t              : pass tag type for the default configuration
package maclaurin_pkg;

   localparam int unsigned STAGES_DEF = 4;
   localparam int unsigned PASSES_DEF = 2;

   // A single pass still needs one tag bit so the tag vectors never collapse to zero width.
   function automatic int unsigned tag_width(input int unsigned passes);
      return (passes > 1) ? $clog2(passes) : 1;
   endfunction

   localparam int unsigned TAG_W_DEF = tag_width(PASSES_DEF);

   typedef logic [TAG_W_DEF-1:0] pass_tag_t;

endpackage

// File: rtl/maclaurin_stage_track.sv
// Occupancy and pass-tag tracker for the series pipe stages.
//
// Each stage owns a valid bit and a pass tag. Together they form a shift register.
// On load_i every stage takes the contents of its predecessor, and stage 0 takes valid_i/tag_i.
// flush_i clears every valid bit and takes priority over load_i.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears valid bits and tags
//   flush_i    : clear all valid bits on the next edge
//   load_i     : advance the shift register by one stage
//   valid_i    : valid bit entering stage 0
//   tag_i      : pass tag entering stage 0
//   valid_o    : occupancy bit per stage
//   tag_last_o : pass tag held by the final stage
module maclaurin_stage_track
   import maclaurin_pkg::*;
#(
   parameter int unsigned STAGES = STAGES_DEF,
   parameter int unsigned TW     = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              valid_i,
   input  logic [TW-1:0]     tag_i,
   output logic [STAGES-1:0] valid_o,
   output logic [TW-1:0]     tag_last_o
);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [TW-1:0]     tag_q [STAGES];
   logic [TW-1:0]     tag_d [STAGES];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      if (flush_i) begin
         // Tags may keep stale values; a tag only has meaning next to a set valid bit.
         valid_d = '0;
      end else if (load_i) begin
         valid_d[0] = valid_i;
         tag_d[0]   = tag_i;
         for (int i = 1; i < int'(STAGES); i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < int'(STAGES); i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign valid_o    = valid_q;
   assign tag_last_o = tag_q[STAGES-1];

endmodule

// File: rtl/maclaurin_pipe_ctrl.sv
// Issue, recirculation and handoff control for a Maclaurin series evaluation pipe.
//
// Each operand passes through the STAGES-deep pipe PASSES times. An item that leaves the final
// stage with passes still to go is fed back into stage 0. That feedback takes priority over a new
// operand. When the final pass completes, the result is held until the consumer accepts it. The
// whole pipe freezes while a completed result is held.
//
// Build option:
//   MACLAURIN_CTRL_PERF_EN : adds 16-bit saturating counters perf_results (handoffs) and
//                            perf_stalls (stall cycles). The counters are cleared by rst only.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop all in-flight operands (priority over stall and accept)
//   in_valid      : new operand offered
//   in_ready      : operand accepted when in_valid & in_ready
//   out_ready     : consumer accepts the result
//   last_ov       : overflow flag from the final stage registers
//   stage_load    : common load enable for all stage register sets
//   recirc_sel    : stage-0 mux select, 1 = final-stage feedback
//   base_addr     : starting LUT address for the item entering stage 0
//   stage_valid   : occupancy per stage
//   out_valid     : final stage holds a completed result
//   out_ov        : overflow qualifier, valid with out_valid
//   perf_results  : (perf build) number of results handed off
//   perf_stalls   : (perf build) number of stall cycles
module maclaurin_pipe_ctrl
   import maclaurin_pkg::*;
#(
   parameter int unsigned STAGES = STAGES_DEF,
   parameter int unsigned PASSES = PASSES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_ready,
   input  logic              last_ov,
   output logic              stage_load,
   output logic              recirc_sel,
   output logic [2:0]        base_addr,
   output logic [STAGES-1:0] stage_valid,
   output logic              out_valid,
   output logic              out_ov
`ifdef MACLAURIN_CTRL_PERF_EN
   ,
   output logic [15:0]       perf_results,
   output logic [15:0]       perf_stalls
`endif
);

   localparam int unsigned TW = tag_width(PASSES);
   localparam logic [TW-1:0] LastTag = TW'(PASSES - 1);

   logic [TW-1:0] tag_last;
   logic [TW-1:0] tag_next;
   logic [TW-1:0] s0_tag;
   logic          s0_valid;
   logic          done;
   logic          stall;
   logic          recirc;
   logic          accept;

   always_comb begin
      done     = stage_valid[STAGES-1] & (tag_last == LastTag);
      stall    = done & ~out_ready;
      recirc   = stage_valid[STAGES-1] & ~done;
      tag_next = tag_last + TW'(1);

      stage_load = ~stall;
      // Feedback owns the stage-0 slot, so a recirculating cycle is never an issue slot.
      in_ready   = stage_load & ~recirc & ~flush;
      accept     = in_valid & in_ready;

      s0_valid = recirc | accept;
      s0_tag   = recirc ? tag_next : '0;

      recirc_sel = recirc;
      // Each pass walks a fresh block of STAGES LUT entries.
      base_addr  = recirc ? 3'(int'(tag_next) * int'(STAGES)) : 3'd0;
      out_valid  = done;
      out_ov     = last_ov & done;
   end

   maclaurin_stage_track #(
      .STAGES (STAGES),
      .TW     (TW)
   ) u_stage_track (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .load_i     (stage_load),
      .valid_i    (s0_valid),
      .tag_i      (s0_tag),
      .valid_o    (stage_valid),
      .tag_last_o (tag_last)
   );

`ifdef MACLAURIN_CTRL_PERF_EN
   logic [15:0] perf_results_q;
   logic [15:0] perf_stalls_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_results_q <= '0;
         perf_stalls_q  <= '0;
      end else begin
         if (done && out_ready && (perf_results_q != 16'hFFFF)) begin
            perf_results_q <= perf_results_q + 16'd1;
         end
         if (stall && (perf_stalls_q != 16'hFFFF)) begin
            perf_stalls_q <= perf_stalls_q + 16'd1;
         end
      end
   end

   assign perf_results = perf_results_q;
   assign perf_stalls  = perf_stalls_q;
`else
   // Performance counters are not built.
`endif

endmodule

// File: tb/tb_maclaurin_pipe_ctrl.sv
// Self-checking bench for maclaurin_pipe_ctrl (default STAGES=4, PASSES=2).
// The scoreboard records the accept cycle and the stall count when each operand enters.
// At each handoff it pops the oldest entry and compares the latency with 8 + stalls seen since.
module tb_maclaurin_pipe_ctrl;

   localparam int unsigned STAGES = 4;
   localparam int unsigned PASSES = 2;
   localparam int          LAT    = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b1;
   logic              last_ov = 1'b0;
   logic              in_ready;
   logic              stage_load;
   logic              recirc_sel;
   logic [2:0]        base_addr;
   logic [STAGES-1:0] stage_valid;
   logic              out_valid;
   logic              out_ov;
`ifdef MACLAURIN_CTRL_PERF_EN
   logic [15:0]       perf_results;
   logic [15:0]       perf_stalls;
`endif

   maclaurin_pipe_ctrl #(
      .STAGES (STAGES),
      .PASSES (PASSES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_ready   (out_ready),
      .last_ov     (last_ov),
      .stage_load  (stage_load),
      .recirc_sel  (recirc_sel),
      .base_addr   (base_addr),
      .stage_valid (stage_valid),
      .out_valid   (out_valid),
      .out_ov      (out_ov)
`ifdef MACLAURIN_CTRL_PERF_EN
      ,
      .perf_results (perf_results),
      .perf_stalls  (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   int stall_cnt = 0;
   int handoffs = 0;

   typedef struct {
      int acc;
      int st;
   } sb_t;
   sb_t sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to the drive point of a later cycle.
   task automatic go(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
      check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({pfx, "_out_ov"}, 32'(out_ov), 32'd0);
      check_eq({pfx, "_recirc_sel"}, 32'(recirc_sel), 32'd0);
      check_eq({pfx, "_base_addr"}, 32'(base_addr), 32'd0);
      check_eq({pfx, "_stage_load"}, 32'(stage_load), 32'd1);
      check_eq({pfx, "_stage_valid"}, 32'(stage_valid), 32'd0);
`ifdef MACLAURIN_CTRL_PERF_EN
      check_eq({pfx, "_perf_results"}, 32'(perf_results), 32'd0);
      check_eq({pfx, "_perf_stalls"}, 32'(perf_stalls), 32'd0);
`endif
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge clk) begin
      sb_t e;
      if (rst || flush) begin
         sb_q.delete();
      end else begin
         if (in_valid && in_ready) sb_q.push_back('{cyc, stall_cnt});
         if (out_valid && out_ready) begin
            handoffs++;
            check_eq("result_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check_eq("latency", 32'(cyc - e.acc), 32'(LAT + stall_cnt - e.st));
            end
         end
         if (out_valid && !out_ready) stall_cnt++;
         if (recirc_sel) check_eq("ready_in_recirc", 32'(in_ready), 32'd0);
      end
   end

   initial begin
      int acc_w0, acc_w1, acc_tot, nout;

      // Reset
      go(3);
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("rst0");

      // Single operand: recirculation at +4, result at +8
      go(1);
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("a_accept", 32'(in_ready), 32'd1);
      go(1);
      in_valid = 1'b0;
      go(3);
      @(negedge clk);
      check_eq("a_recirc_sel", 32'(recirc_sel), 32'd1);
      check_eq("a_base_addr", 32'(base_addr), 32'd4);
      check_eq("a_sv_at4", 32'(stage_valid), 32'b1000);
      check_eq("a_no_out_at4", 32'(out_valid), 32'd0);
      go(1);
      @(negedge clk);
      check_eq("a_sv_at5", 32'(stage_valid), 32'b0001);
      check_eq("a_recirc_at5", 32'(recirc_sel), 32'd0);
      go(3);
      @(negedge clk);
      check_eq("a_out_at8", 32'(out_valid), 32'd1);
      check_eq("a_sv_at8", 32'(stage_valid), 32'b1000);
      check_eq("a_base_at8", 32'(base_addr), 32'd0);
      go(1);
      @(negedge clk);
      check_eq("a_out_at9", 32'(out_valid), 32'd0);
      check_eq("a_sv_at9", 32'(stage_valid), 32'd0);

      // in_valid held for 20 cycles: 4 accepts per 8-cycle window
      go(1);
      acc_w0 = 0;
      acc_w1 = 0;
      acc_tot = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            acc_tot++;
            if (i < 8) acc_w0++;
            else if (i < 16) acc_w1++;
         end
         go(1);
      end
      in_valid = 1'b0;
      check_eq("b_accepts_w0", 32'(acc_w0), 32'd4);
      check_eq("b_accepts_w1", 32'(acc_w1), 32'd4);
      check_eq("b_accepts_total", 32'(acc_tot), 32'd12);
      go(16);
      @(negedge clk);
      check_eq("b_drained_sv", 32'(stage_valid), 32'd0);
      check_eq("b_drained_sb", 32'(sb_q.size()), 32'd0);

      // Consumer back-pressure for 5 cycles while done
      go(1);
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("c_accept", 32'(in_ready), 32'd1);
      go(1);
      in_valid = 1'b0;
      go(7);
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("c_stall_out_valid", 32'(out_valid), 32'd1);
         check_eq("c_stall_sv", 32'(stage_valid), 32'b1000);
         check_eq("c_stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("c_stall_load", 32'(stage_load), 32'd0);
         go(1);
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("c_release_out_valid", 32'(out_valid), 32'd1);
      go(1);
      @(negedge clk);
      check_eq("c_after_out_valid", 32'(out_valid), 32'd0);
      check_eq("c_after_sv", 32'(stage_valid), 32'd0);
      check_eq("c_handoffs", 32'(handoffs), 32'd14);
`ifdef MACLAURIN_CTRL_PERF_EN
      check_eq("c_perf_stalls", 32'(perf_stalls), 32'd5);
      check_eq("c_perf_results", 32'(perf_results), 32'(handoffs));
`endif

      // Flush with 3 items in flight
      go(1);
      in_valid = 1'b1;
      go(3);
      flush = 1'b1;
      @(negedge clk);
      check_eq("d_flush_in_ready", 32'(in_ready), 32'd0);
      check_eq("d_sv_before", 32'(stage_valid), 32'b0111);
      go(1);
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("d_sv_after", 32'(stage_valid), 32'd0);
      nout = 0;
      for (int i = 0; i < 12; i++) begin
         go(1);
         @(negedge clk);
         if (out_valid) nout++;
      end
      check_eq("d_no_out_after_flush", 32'(nout), 32'd0);

      // Overflow qualifier
      go(1);
      last_ov = 1'b1;
      @(negedge clk);
      check_eq("e_ov_idle", 32'(out_ov), 32'd0);
      in_valid = 1'b1;
      go(1);
      in_valid = 1'b0;
      go(3);
      @(negedge clk);
      check_eq("e_ov_recirc", 32'(out_ov), 32'd0);
      go(4);
      @(negedge clk);
      check_eq("e_done_out_valid", 32'(out_valid), 32'd1);
      check_eq("e_ov_done", 32'(out_ov), 32'd1);
      go(1);
      last_ov = 1'b0;

      // Reset mid-stream
      in_valid = 1'b1;
      go(10);
      rst = 1'b1;
      last_ov = 1'b1;
      go(1);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_reset_vals("rst1");
      nout = 0;
      for (int i = 0; i < 12; i++) begin
         go(1);
         @(negedge clk);
         if (out_valid) nout++;
      end
      check_eq("f_no_out_after_rst", 32'(nout), 32'd0);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
